debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, giving the number of independent input channels (one per 4x4 keypad line).
REQ-002 SHALL have parameter LIMIT, default 500000, giving the debounce interval in clock cycles (10 ms at 50 MHz); legal range 1..2^24-1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth per channel; legal range 2..4.
REQ-004 SHALL have parameter IDLE_LEVEL, default 1'b0, giving the stable level loaded into every channel at reset.
REQ-005 SHALL have port i_clk, input, 1 bit: the single system clock, rising-edge active.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port i_switch, input, NUM_CH bits: raw asynchronous switch levels.
REQ-008 SHALL have port o_switch, output, NUM_CH bits: debounced stable levels.
REQ-009 SHALL have port o_rise, output, NUM_CH bits: one-cycle pulse per channel on a debounced 0->1 transition.
REQ-010 SHALL have port o_fall, output, NUM_CH bits: one-cycle pulse per channel on a debounced 1->0 transition.
REQ-011 SHALL have port o_any_change, output, 1 bit: OR of all o_rise and o_fall bits, registered in the same cycle.

Function
REQ-012 SHALL pass each channel through a SYNC_STAGES flop chain; debounce logic SHALL see only the last stage (s_i).
REQ-013 SHALL keep per-channel stable state st_i and counter cnt_i of width $clog2(LIMIT+1).
REQ-014 SHALL, when s_i != st_i and cnt_i < LIMIT-1, increment cnt_i.
REQ-015 SHALL, when s_i != st_i and cnt_i == LIMIT-1, load st_i <= s_i and cnt_i <= 0, and assert the matching edge pulse on the same edge.
REQ-016 SHALL, when s_i == st_i, clear cnt_i to 0 (a glitch restarts the interval).
REQ-017 SHALL therefore update o_switch[i] exactly LIMIT cycles after s_i first differs, provided s_i stays different for all LIMIT cycles; total latency from i_switch is LIMIT+SYNC_STAGES cycles.
REQ-018 SHALL, with LIMIT == 1, accept a new level one cycle after it appears at s_i.
REQ-019 SHALL never wrap cnt_i; cnt_i SHALL NOT exceed LIMIT-1.
REQ-020 SHALL drive o_rise/o_fall high for exactly one cycle per transition; they SHALL never both be high for one channel.
REQ-021 SHALL process channels fully independently; simultaneous qualification on several channels SHALL produce simultaneous pulses.
REQ-022 SHALL drive all outputs directly from registers.

Reset
REQ-023 SHALL, while i_rst_n is low, asynchronously set all synchronizer flops and st_i to IDLE_LEVEL, cnt_i to 0, and o_rise, o_fall and o_any_change to 0.
REQ-024 SHALL discard any in-progress count on reset; no pulse SHALL be produced for the reset itself or on its release.
REQ-025 SHALL begin counting on the first clock edge after i_rst_n deasserts.

Configuration
REQ-026 SHALL use macro DEBOUNCE_BANK_EDGE_EN: when defined, o_rise, o_fall and o_any_change are generated per REQ-015/020.
REQ-027 SHALL, when DEBOUNCE_BANK_EDGE_EN is undefined, remove the pulse registers and tie o_rise, o_fall and o_any_change to constant 0; o_switch behaviour SHALL be unchanged.

Structure
REQ-028 SHALL place DEBOUNCE_LIMIT_10MS_50MHZ (500000), DEFAULT_SYNC_STAGES (2) and function cnt_width(limit) in package debounce_pkg.
REQ-029 SHALL implement one channel as sub-module debounce_cell (synchronizer, counter, stable state, edge pulses), instantiated NUM_CH times by a generate loop.

Verification (NUM_CH=4, LIMIT=8, SYNC_STAGES=2, IDLE_LEVEL=0, macro defined)
REQ-030 SHALL check: ch0 0->1 held 20 cycles -> o_switch[0]=1 exactly 10 cycles after the i_switch edge, and o_rise[0] plus o_any_change high for 1 cycle.
REQ-031 SHALL check: ch1 high for 7 cycles then low -> o_switch[1] stays 0, no pulses; a glitch at cycle 5 of a 12-cycle high restarts the count (update at glitch end + 10).
REQ-032 SHALL check: i_switch=4'hF applied at once -> all 4 o_switch bits and all 4 o_rise bits assert in the same cycle; releasing to 0 gives 4 simultaneous o_fall pulses.
REQ-033 SHALL check: i_rst_n pulsed low at count 5 of a ch2 rise -> outputs 0 immediately, no pulse, and a new full interval is required after release.
REQ-034 SHALL check: LIMIT=1 build -> a one-cycle-stable change propagates after 3 cycles; macro undefined build -> o_rise/o_fall/o_any_change constant 0 throughout REQ-030.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants, helpers and types for the debounce bank.
// Edge-pulse generation is compiled in with `define DEBOUNCE_BANK_EDGE_EN.
package debounce_pkg;

    localparam int DEBOUNCE_LIMIT_10MS_50MHZ = 500000;
    localparam int DEFAULT_SYNC_STAGES       = 2;

    // Counter width able to hold every value 0..limit.
    function automatic int cnt_width(input int limit);
        if (limit < 1) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

endpackage

// File: rtl/debounce_cell.sv
// One debounce channel: synchronizer chain, interval counter, stable level and edge pulses.
// Edge pulses exist only when DEBOUNCE_BANK_EDGE_EN is defined; otherwise they are tied low.
module debounce_cell
    import debounce_pkg::*;
#(
    parameter int   LIMIT       = DEBOUNCE_LIMIT_10MS_50MHZ,
    parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_switch,
    output logic o_switch,
    output logic o_rise,
    output logic o_fall
`ifdef DEBOUNCE_BANK_EDGE_EN
    ,
    output logic o_change_next
`endif
);

    localparam int            CW      = cnt_width(LIMIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   st_q;
    logic [CW-1:0]          cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_switch};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Any sample that agrees with the stable level restarts the interval.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q  <= IDLE_LEVEL;
            cnt_q <= '0;
        end else if (s == st_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            st_q  <= s;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_switch = st_q;

`ifdef DEBOUNCE_BANK_EDGE_EN
    edge_e edge_next;
    logic  rise_q;
    logic  fall_q;

    always_comb begin
        edge_next = EDGE_NONE;
        if ((s != st_q) && (cnt_q == CNT_MAX)) begin
            edge_next = s ? EDGE_RISE : EDGE_FALL;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= (edge_next == EDGE_RISE);
            fall_q <= (edge_next == EDGE_FALL);
        end
    end

    assign o_rise        = rise_q;
    assign o_fall        = fall_q;
    assign o_change_next = (edge_next != EDGE_NONE);
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of NUM_CH independent switch debouncers with a registered any-change flag.
// Define DEBOUNCE_BANK_EDGE_EN to build o_rise/o_fall/o_any_change; otherwise they read 0.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   NUM_CH      = 16,
    parameter int   LIMIT       = DEBOUNCE_LIMIT_10MS_50MHZ,
    parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_switch,
    output logic [NUM_CH-1:0] o_switch,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic              o_any_change
);

`ifdef DEBOUNCE_BANK_EDGE_EN
    logic [NUM_CH-1:0] change_next;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_cell #(
            .LIMIT       (LIMIT),
            .SYNC_STAGES (SYNC_STAGES),
            .IDLE_LEVEL  (IDLE_LEVEL)
        ) u_cell (
            .i_clk         (i_clk),
            .i_rst_n       (i_rst_n),
            .i_switch      (i_switch[i]),
            .o_switch      (o_switch[i]),
            .o_rise        (o_rise[i]),
            .o_fall        (o_fall[i])
`ifdef DEBOUNCE_BANK_EDGE_EN
            ,
            .o_change_next (change_next[i])
`endif
        );
    end

`ifdef DEBOUNCE_BANK_EDGE_EN
    // Registered from the cells' next-pulse terms so it aligns with o_rise/o_fall.
    logic any_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |change_next;
        end
    end

    assign o_any_change = any_q;
`else
    assign o_any_change = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: a LIMIT=8 bank and a LIMIT=1 bank driven by the same inputs.
// Expected pulses follow DEBOUNCE_BANK_EDGE_EN as seen by this file.
module tb_debounce_bank;

    localparam int NUM_CH      = 4;
    localparam int LIMIT       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int W           = 3 * NUM_CH + 1;
`ifdef DEBOUNCE_BANK_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic              i_clk;
    logic              i_rst_n;
    logic [NUM_CH-1:0] i_switch;

    logic [NUM_CH-1:0] a_sw, a_rise, a_fall;
    logic              a_any;
    logic [NUM_CH-1:0] b_sw, b_rise, b_fall;
    logic              b_any;

    logic [W-1:0] obs0, obs1;
    assign obs0 = {a_any, a_fall, a_rise, a_sw};
    assign obs1 = {b_any, b_fall, b_rise, b_sw};

    debounce_bank #(
        .NUM_CH(NUM_CH), .LIMIT(LIMIT), .SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_switch(i_switch),
        .o_switch(a_sw), .o_rise(a_rise), .o_fall(a_fall), .o_any_change(a_any)
    );

    debounce_bank #(
        .NUM_CH(NUM_CH), .LIMIT(1), .SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)
    ) dut_l1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_switch(i_switch),
        .o_switch(b_sw), .o_rise(b_rise), .o_fall(b_fall), .o_any_change(b_any)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    initial begin
        #100000;
        fail_cnt++;
        check_cnt++;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // A new level is accepted once the last LIMIT synchronized samples all disagree with the stable level.
    logic [NUM_CH-1:0] dly_q[$];
    logic [NUM_CH-1:0] s_hist[$];
    logic [NUM_CH-1:0] st_m [2];
    logic [W-1:0]      exp_q[$];

    task automatic model_reset();
        dly_q.delete();
        for (int i = 0; i < SYNC_STAGES; i++) dly_q.push_back('0);
        s_hist.delete();
        st_m[0] = '0;
        st_m[1] = '0;
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    task automatic model_edge();
        logic [NUM_CH-1:0] s, flip, nst, rise, fall;
        int lim;
        bit all_diff;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        s = dly_q.pop_front();
        dly_q.push_back(i_switch);
        s_hist.push_back(s);
        if (s_hist.size() > LIMIT) void'(s_hist.pop_front());
        for (int k = 0; k < 2; k++) begin
            lim  = (k == 0) ? LIMIT : 1;
            flip = '0;
            if (s_hist.size() >= lim) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    all_diff = 1'b1;
                    for (int j = s_hist.size() - lim; j < s_hist.size(); j++)
                        if (s_hist[j][ch] == st_m[k][ch]) all_diff = 1'b0;
                    flip[ch] = all_diff;
                end
            end
            nst  = st_m[k] ^ flip;
            rise = EDGE_EN ? (flip & nst)  : '0;
            fall = EDGE_EN ? (flip & ~nst) : '0;
            st_m[k] = nst;
            exp_q.push_back({EDGE_EN & (|flip), fall, rise, nst});
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_pop(input string tag);
        logic [W-1:0] e0, e1;
        if (exp_q.size() < 2) begin
            chk({tag, "_queue"}, W'(exp_q.size()), W'(2));
            return;
        end
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        chk(tag, obs0, e0);
        chk({tag, "_l1"}, obs1, e1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input string tag);
        @(posedge i_clk);
        model_edge();
        #1;
        check_pop(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_pop(tag);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        i_rst_n  = 1'b1;
        i_switch = '0;
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_pop("reset_init");
        chk("reset_outputs", obs0, '0);
        ticks(3, "in_reset");
        i_rst_n = 1'b1;
        ticks(2, "post_reset");

        // ch0 rise held 20 cycles
        i_switch[0] = 1'b1;
        ticks(9, "ch0_rise");
        chk("ch0_before_10", W'(a_sw[0]), W'(0));
        tick("ch0_rise");
        chk("ch0_at_10", W'(a_sw[0]), W'(1));
        chk("ch0_rise_pulse", W'(a_rise[0]), W'(EDGE_EN));
        chk("ch0_any_pulse", W'(a_any), W'(EDGE_EN));
        tick("ch0_rise");
        chk("ch0_rise_one_cycle", W'(a_rise[0]), W'(0));
        ticks(9, "ch0_hold");
        i_switch[0] = 1'b0;
        ticks(12, "ch0_fall");

        // ch1 short pulse, then glitched high
        i_switch[1] = 1'b1;
        ticks(7, "ch1_short");
        i_switch[1] = 1'b0;
        ticks(12, "ch1_short");
        chk("ch1_short_rejected", W'(a_sw[1]), W'(0));
        i_switch[1] = 1'b1;
        ticks(4, "ch1_glitch");
        i_switch[1] = 1'b0;
        tick("ch1_glitch");
        i_switch[1] = 1'b1;
        ticks(9, "ch1_glitch");
        chk("ch1_glitch_before_10", W'(a_sw[1]), W'(0));
        tick("ch1_glitch");
        chk("ch1_glitch_at_10", W'(a_sw[1]), W'(1));
        ticks(2, "ch1_glitch");
        i_switch[1] = 1'b0;
        ticks(12, "ch1_fall");

        // all channels at once
        i_switch = 4'hF;
        ticks(10, "all_rise");
        chk("all_sw_high", W'(a_sw), W'(4'hF));
        chk("all_rise", W'(a_rise), W'(EDGE_EN ? 4'hF : 4'h0));
        ticks(3, "all_hold");
        i_switch = 4'h0;
        ticks(10, "all_fall");
        chk("all_sw_low", W'(a_sw), W'(0));
        chk("all_fall", W'(a_fall), W'(EDGE_EN ? 4'hF : 4'h0));
        ticks(2, "all_fall");

        // reset in the middle of a ch2 interval
        i_switch[0] = 1'b1;
        ticks(12, "ch0_up");
        i_switch[2] = 1'b1;
        ticks(7, "ch2_count");
        async_reset("mid_reset");
        chk("mid_reset_outputs", obs0, '0);
        ticks(3, "mid_reset_hold");
        i_rst_n = 1'b1;
        ticks(9, "after_release");
        chk("ch2_no_early", W'(a_sw[2]), W'(0));
        tick("after_release");
        chk("ch2_full_interval", W'(a_sw[2]), W'(1));
        chk("rise_after_release", W'(a_rise), W'(EDGE_EN ? 4'b0101 : 4'b0000));
        ticks(2, "after_release");

        // one-cycle input on the LIMIT=1 bank
        i_switch = '0;
        ticks(12, "settle");
        i_switch[3] = 1'b1;
        tick("l1_pulse");
        i_switch[3] = 1'b0;
        tick("l1_pulse");
        chk("l1_before", W'(b_sw[3]), W'(0));
        tick("l1_pulse");
        chk("l1_at_3", W'(b_sw[3]), W'(1));
        chk("l1_rise", W'(b_rise[3]), W'(EDGE_EN));
        tick("l1_pulse");
        chk("l1_back", W'(b_sw[3]), W'(0));
        chk("l1_fall", W'(b_fall[3]), W'(EDGE_EN));
        ticks(4, "l1_settle");

        // randomized toggling with varying glitch density
        for (int i = 0; i < 600; i++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, (i < 300) ? 11 : 4) == 0)
                    i_switch[ch] = ~i_switch[ch];
            end
            if (i == 350) begin
                async_reset("rand_reset");
                ticks(2, "rand_reset_hold");
                i_rst_n = 1'b1;
            end
            tick("random");
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
